// File: rtl/pll_reset_sequencer.sv
// PLL bring-up sequencer: pulses PLL reset, waits for a stable lock, then releases the downstream reset.
// Optional macro PLL_LOSS_COUNT_EN enables the saturating loss_count register (otherwise loss_count is tied to 0).
module pll_reset_sequencer #(
    parameter int PLL_RST_CYCLES      = 16,
    parameter int LOCK_TIMEOUT_CYCLES = 25000,
    parameter int LOCK_STABLE_CYCLES  = 250,
    parameter int MAX_RETRIES         = 3
) (
    input  logic       clk_25mhz,
    input  logic       rst_n,
    input  logic       pll_locked,
    input  logic       restart,
    output logic       pll_rst,
    output logic       sys_rst_n,
    output logic       ready,
    output logic       fault,
    output logic [7:0] loss_count
);

    localparam int MAX_A = (PLL_RST_CYCLES > LOCK_TIMEOUT_CYCLES) ? PLL_RST_CYCLES : LOCK_TIMEOUT_CYCLES;
    localparam int MAX_T = (MAX_A > LOCK_STABLE_CYCLES) ? MAX_A : LOCK_STABLE_CYCLES;
    localparam int CNT_W = (MAX_T > 1) ? $clog2(MAX_T) : 1;
    localparam int RTY_W = (MAX_RETRIES > 0) ? $clog2(MAX_RETRIES + 1) : 1;

    localparam logic [CNT_W-1:0] RST_LAST     = CNT_W'(PLL_RST_CYCLES - 1);
    localparam logic [CNT_W-1:0] TIMEOUT_LAST = CNT_W'(LOCK_TIMEOUT_CYCLES - 1);
    // The WAIT_LOCK sample that enters STABLE already counts as the first locked cycle.
    localparam logic [CNT_W-1:0] STABLE_LAST  =
        CNT_W'((LOCK_STABLE_CYCLES >= 2) ? LOCK_STABLE_CYCLES - 2 : 0);
    localparam logic [RTY_W-1:0] RTY_MAX      = RTY_W'(MAX_RETRIES);

    typedef enum logic [2:0] {
        RESET_PLL,
        WAIT_LOCK,
        STABLE,
        RUN,
        FAULT
    } state_t;

    state_t            state, state_nx;
    logic [CNT_W-1:0]  cnt, cnt_nx;
    logic [RTY_W-1:0]  retries, retries_nx;
    logic              sync_p0;
    logic              lock_s;

    always_comb begin
        state_nx   = state;
        cnt_nx     = cnt + CNT_W'(1);
        retries_nx = retries;
        case (state)
            RESET_PLL: begin
                if (cnt == RST_LAST) begin
                    state_nx = WAIT_LOCK;
                    cnt_nx   = '0;
                end
            end
            WAIT_LOCK: begin
                if (lock_s) begin
                    state_nx = STABLE;
                    cnt_nx   = '0;
                end else if (cnt == TIMEOUT_LAST) begin
                    cnt_nx = '0;
                    if (retries < RTY_MAX) begin
                        state_nx   = RESET_PLL;
                        retries_nx = retries + RTY_W'(1);
                    end else begin
                        state_nx = FAULT;
                    end
                end
            end
            STABLE: begin
                if (!lock_s) begin
                    state_nx = WAIT_LOCK;
                    cnt_nx   = '0;
                end else if (cnt == STABLE_LAST) begin
                    state_nx = RUN;
                    cnt_nx   = '0;
                end
            end
            RUN: begin
                cnt_nx = '0;
                if (!lock_s) begin
                    state_nx   = RESET_PLL;
                    retries_nx = '0;
                end
            end
            FAULT: begin
                cnt_nx = '0;
                if (restart) begin
                    state_nx   = RESET_PLL;
                    retries_nx = '0;
                end
            end
            default: begin
                state_nx = RESET_PLL;
                cnt_nx   = '0;
            end
        endcase
    end

    // Outputs are decoded from the next state so they stay registered and aligned with state.
    always_ff @(posedge clk_25mhz) begin
        if (!rst_n) begin
            state     <= RESET_PLL;
            cnt       <= '0;
            retries   <= '0;
            sync_p0   <= 1'b0;
            lock_s    <= 1'b0;
            pll_rst   <= 1'b1;
            sys_rst_n <= 1'b0;
            ready     <= 1'b0;
            fault     <= 1'b0;
        end else begin
            sync_p0   <= pll_locked;
            lock_s    <= sync_p0;
            state     <= state_nx;
            cnt       <= cnt_nx;
            retries   <= retries_nx;
            pll_rst   <= (state_nx == RESET_PLL) || (state_nx == FAULT);
            sys_rst_n <= (state_nx == RUN);
            ready     <= (state_nx == RUN);
            fault     <= (state_nx == FAULT);
        end
    end

`ifdef PLL_LOSS_COUNT_EN
    function automatic logic [7:0] sat_inc8(input logic [7:0] v);
        return (v == 8'hFF) ? v : v + 8'd1;
    endfunction

    logic [7:0] loss_q;

    always_ff @(posedge clk_25mhz) begin
        if (!rst_n) begin
            loss_q <= '0;
        end else if ((state == RUN) && !lock_s) begin
            loss_q <= sat_inc8(loss_q);
        end
    end

    assign loss_count = loss_q;
`else
    assign loss_count = 8'd0;
`endif

endmodule

// File: tb/tb_pll_reset_sequencer.sv
// Directed bench for pll_reset_sequencer with short timing parameters (4/20/8/2).
// Expected loss_count values follow PLL_LOSS_COUNT_EN when the bench is built with that macro.
module tb_pll_reset_sequencer;

`ifdef PLL_LOSS_COUNT_EN
    localparam bit LC_EN = 1'b1;
`else
    localparam bit LC_EN = 1'b0;
`endif

    logic       clk_25mhz = 1'b0;
    logic       rst_n;
    logic       pll_locked;
    logic       restart;
    logic       pll_rst;
    logic       sys_rst_n;
    logic       ready;
    logic       fault;
    logic [7:0] loss_count;

    int vectors     = 0;
    int miscompares = 0;

    always #20 clk_25mhz = ~clk_25mhz;

    pll_reset_sequencer #(
        .PLL_RST_CYCLES     (4),
        .LOCK_TIMEOUT_CYCLES(20),
        .LOCK_STABLE_CYCLES (8),
        .MAX_RETRIES        (2)
    ) dut (
        .clk_25mhz (clk_25mhz),
        .rst_n     (rst_n),
        .pll_locked(pll_locked),
        .restart   (restart),
        .pll_rst   (pll_rst),
        .sys_rst_n (sys_rst_n),
        .ready     (ready),
        .fault     (fault),
        .loss_count(loss_count)
    );

    task automatic tick(input int n = 1);
        repeat (n) @(posedge clk_25mhz);
        #1;
    endtask

    task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    initial begin
        int   rises;
        int   highs;
        logic prev;

        rst_n      = 1'b0;
        pll_locked = 1'b0;
        restart    = 1'b0;
        tick(3);
        check("rst_pll_rst",   pll_rst,    1);
        check("rst_sys_rst_n", sys_rst_n,  0);
        check("rst_ready",     ready,      0);
        check("rst_fault",     fault,      0);
        check("rst_loss",      loss_count, 0);

        // Bring-up: 4-cycle PLL reset pulse, lock at cycle 10, RUN 8 cycles after lock_s rises.
        rst_n = 1'b1;
        tick(1);
        check("boot_pulse_e0", pll_rst, 1);
        tick(2);
        check("boot_pulse_e2", pll_rst, 1);
        tick(1);
        check("boot_pulse_end", pll_rst, 0);
        tick(6);
        pll_locked = 1'b1;
        tick(9);
        check("boot_ready_early", ready,     0);
        check("boot_sysrst_early", sys_rst_n, 0);
        tick(1);
        check("boot_ready",  ready,     1);
        check("boot_sysrst", sys_rst_n, 1);

        // Three single-cycle lock losses in RUN, re-locking each time.
        for (int i = 1; i <= 3; i++) begin
            pll_locked = 1'b0;
            tick(1);
            pll_locked = 1'b1;
            tick(1);
            check("loss_ready_hold", ready, 1);
            tick(1);
            check("loss_ready_drop",  ready,     0);
            check("loss_sysrst_drop", sys_rst_n, 0);
            check("loss_pll_rst",     pll_rst,   1);
            check("loss_count",       loss_count, LC_EN ? 8'(i) : 8'd0);
            tick(3);
            check("loss_pulse_last", pll_rst, 1);
            tick(1);
            check("loss_pulse_end", pll_rst, 0);
            tick(7);
            check("loss_relock_early", ready, 0);
            tick(1);
            check("loss_relock_ready", ready, 1);
        end

        // Reset asserted while in RUN.
        rst_n = 1'b0;
        tick(1);
        check("midrst_ready",   ready,      0);
        check("midrst_sysrst",  sys_rst_n,  0);
        check("midrst_pll_rst", pll_rst,    1);
        check("midrst_loss",    loss_count, 0);
        check("midrst_fault",   fault,      0);
        tick(2);

        // Full-length pulse after release, then a one-cycle lock glitch in STABLE.
        rst_n = 1'b1;
        tick(3);
        check("rerel_pulse_e2", pll_rst, 1);
        tick(1);
        check("rerel_pulse_end", pll_rst, 0);
        tick(2);
        pll_locked = 1'b0;
        tick(1);
        pll_locked = 1'b1;
        tick(5);
        check("glitch_no_early_run", ready, 0);
        tick(4);
        check("glitch_ready_early", ready, 0);
        tick(1);
        check("glitch_ready", ready, 1);

        // Lock never returns: initial pulse plus two retries, then FAULT.
        pll_locked = 1'b0;
        rises = 0;
        highs = 0;
        prev  = pll_rst;
        for (int k = 1; k <= 74; k++) begin
            tick(1);
            if (pll_rst && !prev) rises++;
            if (pll_rst) highs++;
            prev = pll_rst;
        end
        check("retry_no_fault_yet", fault, 0);
        check("retry_pulse_count", 8'(rises), 3);
        check("retry_pulse_cycles", 8'(highs), 12);
        tick(1);
        check("fault_flag",    fault,      1);
        check("fault_pll_rst", pll_rst,    1);
        check("fault_sysrst",  sys_rst_n,  0);
        check("fault_ready",   ready,      0);
        check("fault_loss",    loss_count, LC_EN ? 8'd1 : 8'd0);
        tick(2);
        check("fault_hold", fault, 1);

        // Restart leaves FAULT with a fresh 4-cycle pulse.
        restart = 1'b1;
        tick(1);
        restart = 1'b0;
        check("restart_fault_clr", fault,   0);
        check("restart_pll_rst",   pll_rst, 1);
        tick(3);
        check("restart_pulse_last", pll_rst, 1);
        tick(1);
        check("restart_pulse_end", pll_rst, 0);
        restart = 1'b1;
        tick(1);
        restart = 1'b0;
        check("restart_ignored_pll", pll_rst, 0);
        check("restart_ignored_flt", fault,   0);

        // Lock arrives on the same cycle the WAIT_LOCK timeout expires: lock wins.
        tick(16);
        pll_locked = 1'b1;
        tick(3);
        check("tie_lock_wins", pll_rst, 0);
        check("tie_no_fault",  fault,   0);
        tick(6);
        check("tie_ready_early", ready, 0);
        tick(1);
        check("tie_ready", ready, 1);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
